// File: rtl/rs_issue_scheduler.sv
// ============================================================================
// Module   : rs_issue_scheduler
// Purpose  : Reservation station with CDB wake-up and lowest-index issue select
//            feeding a combinational ALU through a registered issue port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int RS_LOG  = 4,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clear,
    input  logic               D_valid,
    input  logic [OP_LOG-1:0]  D_op,
    input  logic               D_Qj_busy,
    input  logic               D_Qk_busy,
    input  logic [ROB_LOG-1:0] D_Qj,
    input  logic [ROB_LOG-1:0] D_Qk,
    input  logic [31:0]        D_Vj,
    input  logic [31:0]        D_Vk,
    input  logic [31:0]        D_Imm,
    input  logic [31:0]        D_CurPC,
    input  logic [ROB_LOG-1:0] D_DestRob,
    output logic               full,
    input  logic               ALU_enable,
    input  logic [ROB_LOG-1:0] ALU_RobId,
    input  logic [31:0]        ALU_value,
    input  logic               LSB_enable,
    input  logic [ROB_LOG-1:0] LSB_RobId,
    input  logic [31:0]        LSB_value,
    output logic               RS_valid,
    output logic [OP_LOG-1:0]  RS_op,
    output logic [31:0]        RS_Vj,
    output logic [31:0]        RS_Vk,
    output logic [31:0]        RS_Imm,
    output logic [ROB_LOG-1:0] RS_DestRob,
    output logic [31:0]        RS_CurPC
);

    logic               r_busy    [RS_SIZE];
    logic [OP_LOG-1:0]  r_op      [RS_SIZE];
    logic               r_qj_busy [RS_SIZE];
    logic [ROB_LOG-1:0] r_qj      [RS_SIZE];
    logic [31:0]        r_vj      [RS_SIZE];
    logic               r_qk_busy [RS_SIZE];
    logic [ROB_LOG-1:0] r_qk      [RS_SIZE];
    logic [31:0]        r_vk      [RS_SIZE];
    logic [31:0]        r_imm     [RS_SIZE];
    logic [ROB_LOG-1:0] r_dest    [RS_SIZE];
    logic [31:0]        r_pc      [RS_SIZE];
    logic [RS_LOG:0]    r_count;

    logic               r_rs_valid;
    logic [OP_LOG-1:0]  r_rs_op;
    logic [31:0]        r_rs_vj;
    logic [31:0]        r_rs_vk;
    logic [31:0]        r_rs_imm;
    logic [ROB_LOG-1:0] r_rs_dest;
    logic [31:0]        r_rs_pc;

    logic               w_full;
    logic               w_dispatch;
    logic               w_sel_found;
    logic [RS_LOG-1:0]  w_sel_idx;
    logic [RS_LOG-1:0]  w_free_idx;
    logic               w_dj_hit;
    logic               w_dk_hit;

    // ALU wins when both buses carry the same tag.
    function automatic logic bus_hit(input logic [ROB_LOG-1:0] tag);
        return (ALU_enable && (ALU_RobId == tag)) || (LSB_enable && (LSB_RobId == tag));
    endfunction

    function automatic logic [31:0] bus_val(input logic [ROB_LOG-1:0] tag);
        return (ALU_enable && (ALU_RobId == tag)) ? ALU_value : LSB_value;
    endfunction

    assign w_full     = (r_count == (RS_LOG+1)'(RS_SIZE));
    assign w_dispatch = D_valid && !w_full;
    assign w_dj_hit   = D_Qj_busy && bus_hit(D_Qj);
    assign w_dk_hit   = D_Qk_busy && bus_hit(D_Qk);

    // Descending scan so the last hit recorded is the lowest index.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = RS_LOG'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = RS_LOG'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_busy[i]    <= 1'b0;
                r_op[i]      <= '0;
                r_qj_busy[i] <= 1'b0;
                r_qj[i]      <= '0;
                r_vj[i]      <= '0;
                r_qk_busy[i] <= 1'b0;
                r_qk[i]      <= '0;
                r_vk[i]      <= '0;
                r_imm[i]     <= '0;
                r_dest[i]    <= '0;
                r_pc[i]      <= '0;
            end
            r_count    <= '0;
            r_rs_valid <= 1'b0;
            r_rs_op    <= '0;
            r_rs_vj    <= '0;
            r_rs_vk    <= '0;
            r_rs_imm   <= '0;
            r_rs_dest  <= '0;
            r_rs_pc    <= '0;
        end else if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_busy[i] <= 1'b0;
            end
            r_count    <= '0;
            r_rs_valid <= 1'b0;
        end else if (!rdy) begin
            r_rs_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i] && bus_hit(r_qj[i])) begin
                    r_qj_busy[i] <= 1'b0;
                    r_vj[i]      <= bus_val(r_qj[i]);
                end
                if (r_busy[i] && r_qk_busy[i] && bus_hit(r_qk[i])) begin
                    r_qk_busy[i] <= 1'b0;
                    r_vk[i]      <= bus_val(r_qk[i]);
                end
            end

            r_rs_valid <= w_sel_found;
            if (w_sel_found) begin
                r_busy[w_sel_idx] <= 1'b0;
                r_rs_op           <= r_op[w_sel_idx];
                r_rs_vj           <= r_vj[w_sel_idx];
                r_rs_vk           <= r_vk[w_sel_idx];
                r_rs_imm          <= r_imm[w_sel_idx];
                r_rs_dest         <= r_dest[w_sel_idx];
                r_rs_pc           <= r_pc[w_sel_idx];
            end

            // Free slot comes from registered state, so it never aliases the issuing entry.
            if (w_dispatch) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= D_op;
                r_qj_busy[w_free_idx] <= D_Qj_busy && !w_dj_hit;
                r_qj[w_free_idx]      <= D_Qj;
                r_vj[w_free_idx]      <= w_dj_hit ? bus_val(D_Qj) : D_Vj;
                r_qk_busy[w_free_idx] <= D_Qk_busy && !w_dk_hit;
                r_qk[w_free_idx]      <= D_Qk;
                r_vk[w_free_idx]      <= w_dk_hit ? bus_val(D_Qk) : D_Vk;
                r_imm[w_free_idx]     <= D_Imm;
                r_dest[w_free_idx]    <= D_DestRob;
                r_pc[w_free_idx]      <= D_CurPC;
            end

            if (w_dispatch && !w_sel_found) begin
                r_count <= r_count + (RS_LOG+1)'(1);
            end else if (!w_dispatch && w_sel_found) begin
                r_count <= r_count - (RS_LOG+1)'(1);
            end
        end
    end

    assign full       = w_full;
    assign RS_valid   = r_rs_valid;
    assign RS_op      = r_rs_op;
    assign RS_Vj      = r_rs_vj;
    assign RS_Vk      = r_rs_vk;
    assign RS_Imm     = r_rs_imm;
    assign RS_DestRob = r_rs_dest;
    assign RS_CurPC   = r_rs_pc;

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
// ============================================================================
// Module   : tb_rs_issue_scheduler
// Purpose  : Directed plus random stimulus against a cycle-level reference
//            model, with a scoreboard monitor comparing the issue port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        D_valid = 1'b0;
    logic [5:0]  D_op = '0;
    logic        D_Qj_busy = 1'b0, D_Qk_busy = 1'b0;
    logic [3:0]  D_Qj = '0, D_Qk = '0, D_DestRob = '0;
    logic [31:0] D_Vj = '0, D_Vk = '0, D_Imm = '0, D_CurPC = '0;
    logic        ALU_enable = 1'b0, LSB_enable = 1'b0;
    logic [3:0]  ALU_RobId = '0, LSB_RobId = '0;
    logic [31:0] ALU_value = '0, LSB_value = '0;
    logic        full, RS_valid;
    logic [5:0]  RS_op;
    logic [31:0] RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
    logic [3:0]  RS_DestRob;

    rs_issue_scheduler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .D_valid(D_valid), .D_op(D_op),
        .D_Qj_busy(D_Qj_busy), .D_Qk_busy(D_Qk_busy),
        .D_Qj(D_Qj), .D_Qk(D_Qk), .D_Vj(D_Vj), .D_Vk(D_Vk),
        .D_Imm(D_Imm), .D_CurPC(D_CurPC), .D_DestRob(D_DestRob),
        .full(full),
        .ALU_enable(ALU_enable), .ALU_RobId(ALU_RobId), .ALU_value(ALU_value),
        .LSB_enable(LSB_enable), .LSB_RobId(LSB_RobId), .LSB_value(LSB_value),
        .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
        .RS_Imm(RS_Imm), .RS_DestRob(RS_DestRob), .RS_CurPC(RS_CurPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        bit          qjb, qkb;
        logic [3:0]  qj, qk, dest;
        logic [31:0] vj, vk, imm, pc;
    } ent_t;

    typedef struct {
        bit          valid, full;
        logic [5:0]  op;
        logic [3:0]  dest;
        logic [31:0] vj, vk, imm, pc;
    } exp_t;

    ent_t   m [16];
    int     m_cnt;
    exp_t   m_out;
    exp_t   expq [$];
    int     total = 0;
    int     bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit bus_hit(input logic [3:0] tag, output logic [31:0] v);
        v = '0;
        if (ALU_enable && ALU_RobId == tag) begin v = ALU_value; return 1'b1; end
        if (LSB_enable && LSB_RobId == tag) begin v = LSB_value; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = '{default: '0};
        m_cnt = 0;
        m_out = '{default: '0};
    endtask

    // Reference behaviour for one clock edge given the inputs currently applied.
    task automatic model_step();
        int sel = -1;
        int fr  = -1;
        int was = m_cnt;
        logic [31:0] v;
        if (clear) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            m_cnt = 0;
            m_out.valid = 0;
        end else if (!rdy) begin
            m_out.valid = 0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
                if (fr < 0 && !m[i].busy) fr = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy && m[i].qjb && bus_hit(m[i].qj, v)) begin m[i].qjb = 0; m[i].vj = v; end
                if (m[i].busy && m[i].qkb && bus_hit(m[i].qk, v)) begin m[i].qkb = 0; m[i].vk = v; end
            end
            m_out.valid = (sel >= 0);
            if (sel >= 0) begin
                m_out.op = m[sel].op;   m_out.vj = m[sel].vj;   m_out.vk = m[sel].vk;
                m_out.imm = m[sel].imm; m_out.dest = m[sel].dest; m_out.pc = m[sel].pc;
                m[sel].busy = 0;
                m_cnt--;
            end
            if (D_valid && was < 16) begin
                m[fr].busy = 1;  m[fr].op = D_op;
                m[fr].qj = D_Qj; m[fr].qk = D_Qk;
                m[fr].qjb = D_Qj_busy; m[fr].vj = D_Vj;
                m[fr].qkb = D_Qk_busy; m[fr].vk = D_Vk;
                if (D_Qj_busy && bus_hit(D_Qj, v)) begin m[fr].qjb = 0; m[fr].vj = v; end
                if (D_Qk_busy && bus_hit(D_Qk, v)) begin m[fr].qkb = 0; m[fr].vk = v; end
                m[fr].imm = D_Imm; m[fr].dest = D_DestRob; m[fr].pc = D_CurPC;
                m_cnt++;
            end
        end
        m_out.full = (m_cnt == 16);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        expq.push_back(m_out);
        #1;
    endtask

    task automatic idle();
        D_valid = 0; ALU_enable = 0; LSB_enable = 0; clear = 0; rdy = 1;
    endtask

    task automatic disp(input logic [5:0] op, input bit qjb, input logic [3:0] qj, input logic [31:0] vj,
                        input bit qkb, input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] dest);
        D_valid = 1; D_op = op;
        D_Qj_busy = qjb; D_Qj = qj; D_Vj = vj;
        D_Qk_busy = qkb; D_Qk = qk; D_Vk = vk;
        D_DestRob = dest; D_Imm = $urandom; D_CurPC = $urandom;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t r;
            r = expq.pop_front();
            chk("RS_valid", 32'(RS_valid), 32'(r.valid));
            chk("full", 32'(full), 32'(r.full));
            chk("RS_op", 32'(RS_op), 32'(r.op));
            chk("RS_Vj", RS_Vj, r.vj);
            chk("RS_Vk", RS_Vk, r.vk);
            chk("RS_Imm", RS_Imm, r.imm);
            chk("RS_DestRob", 32'(RS_DestRob), 32'(r.dest));
            chk("RS_CurPC", RS_CurPC, r.pc);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset RS_valid", 32'(RS_valid), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset RS_Vj", RS_Vj, 32'd0);
        chk("reset RS_op", 32'(RS_op), 32'd0);
        rst = 0;

        // Basic issue: ADD 5+7 -> rob 3
        idle(); disp(6'd1, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7, 4'd3); step();
        idle(); repeat (3) step();

        // Wake-up from LSB two cycles after dispatch
        disp(6'd2, 1, 4'd2, 32'd0, 0, 4'd0, 32'd1, 4'd4); step();
        idle(); step();
        LSB_enable = 1; LSB_RobId = 4'd2; LSB_value = 32'd10; step();
        idle(); repeat (2) step();

        // Same-cycle capture from ALU
        disp(6'd3, 0, 4'd0, 32'd9, 1, 4'd5, 32'd0, 4'd6);
        ALU_enable = 1; ALU_RobId = 4'd5; ALU_value = 32'hDEADBEEF; step();
        idle(); repeat (2) step();

        // Fill all entries on tag 9, then a dropped 17th dispatch
        for (int i = 0; i < 16; i++) begin
            disp(6'(i + 1), 1, 4'd9, 32'd0, 0, 4'd0, 32'(i), 4'(i)); step();
        end
        disp(6'd63, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2, 4'd15); step();
        idle(); ALU_enable = 1; ALU_RobId = 4'd9; ALU_value = 32'h1234_5678; step();
        idle(); repeat (18) step();

        // Clear with simultaneous dispatch
        for (int i = 0; i < 4; i++) begin
            disp(6'd5, 1, 4'd12, 32'd0, 0, 4'd0, 32'd1, 4'(i)); step();
        end
        idle(); clear = 1; disp(6'd7, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1, 4'd8); step();
        idle(); LSB_enable = 1; LSB_RobId = 4'd12; LSB_value = 32'd3; step();
        idle(); repeat (2) step();

        // rdy low for 3 cycles while an entry is ready
        disp(6'd8, 0, 4'd0, 32'd11, 0, 4'd0, 32'd22, 4'd1); step();
        idle(); rdy = 0; repeat (3) step();
        idle(); repeat (2) step();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                disp(6'($urandom_range(1, 63)), bit'($urandom_range(0, 1)), 4'($urandom),
                     $urandom, bit'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom));
            ALU_enable = ($urandom_range(0, 1) == 1); ALU_RobId = 4'($urandom); ALU_value = $urandom;
            LSB_enable = ($urandom_range(0, 1) == 1); LSB_RobId = 4'($urandom); LSB_value = $urandom;
            clear = ($urandom_range(0, 39) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            step();
        end

        // Async reset while RS_valid is high
        idle(); disp(6'd9, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2, 4'd2); step();
        idle(); step();
        @(negedge clk); #1;
        rst = 1; #1;
        chk("async RS_valid", 32'(RS_valid), 32'd0);
        chk("async full", 32'(full), 32'd0);
        chk("async RS_Vj", RS_Vj, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        idle(); disp(6'd4, 0, 4'd0, 32'd77, 0, 4'd0, 32'd88, 4'd5); step();
        idle(); repeat (2) step();

        @(negedge clk); #1;
        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
